// File: rtl/yolo_pkg.sv
// Shared definitions for the YOLO accelerator task sequencer.
package yolo_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LD_W,
      W_WAIT,
      LD_F,
      F_WAIT,
      CALC,
      C_WAIT,
      WB,
      WB_WAIT,
      FIN
   } state_t;

   // Field positions inside the AXI4-Lite command word reg0.
   localparam int unsigned CMD_START_BIT = 2;
   localparam int unsigned CMD_POOL_BIT  = 3;
   localparam int unsigned CMD_NTILE_LSB = 8;
   localparam int unsigned CMD_NOCG_LSB  = 16;

endpackage

// File: rtl/yolo_loop_cnt.sv
// Nested two-level loop counter: the inner index runs 0..inner_lim.
// When the inner index is at its limit, a step clears it and advances the outer index.
// Both indices hold when both are at their limits, so neither counter ever wraps.
module yolo_loop_cnt #(
   parameter int unsigned INNER_W = 8,
   parameter int unsigned OUTER_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               step,
   input  logic [INNER_W-1:0] inner_lim,
   input  logic [OUTER_W-1:0] outer_lim,
   output logic [INNER_W-1:0] inner_idx,
   output logic [OUTER_W-1:0] outer_idx,
   output logic               inner_last,
   output logic               outer_last
);

   assign inner_last = (inner_idx == inner_lim);
   assign outer_last = (outer_idx == outer_lim);

   // Index registers: clear on task start, advance on each completed iteration.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inner_idx <= '0;
         outer_idx <= '0;
      end else if (clr) begin
         inner_idx <= '0;
         outer_idx <= '0;
      end else if (step) begin
         if (!inner_last) begin
            inner_idx <= inner_idx + 1'b1;
         end else if (!outer_last) begin
            inner_idx <= '0;
            outer_idx <= outer_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/yolo_task_sched.sv
// Layer sequencer: decodes the command word and walks weight load, feature load,
// compute and write-back for every tile of every output-channel group.
module yolo_task_sched
   import yolo_pkg::*;
#(
   parameter int unsigned TILE_W = 8,
   parameter int unsigned OCG_W  = 8
) (
   input  logic              sclk,
   input  logic              s_rst_n,
   input  logic [31:0]       slave_lite_reg0,
   output logic              ldw_start,
   input  logic              ldw_done,
   output logic              ldf_start,
   input  logic              ldf_done,
   output logic              calc_start,
   input  logic              calc_done,
   output logic              wb_start,
   input  logic              wb_done,
   output logic              pool_en,
   output logic [TILE_W-1:0] tile_idx,
   output logic [OCG_W-1:0]  ocg_idx,
   output logic              busy,
   output logic              cmd_err,
   output logic              task_finish
);

   state_t              state;
   state_t              state_next;
   logic                reg0_2_d;
   logic                start_edge;
   logic [TILE_W-1:0]   n_tile_m1;
   logic [OCG_W-1:0]    n_ocg_m1;
   logic                cnt_clr;
   logic                cnt_step;
   logic                tile_last;
   logic                ocg_last;
   logic                unused_cmd;

   assign start_edge = slave_lite_reg0[CMD_START_BIT] & ~reg0_2_d;
   assign unused_cmd = ^{slave_lite_reg0[31:24], slave_lite_reg0[7:4], slave_lite_reg0[1:0]};

   yolo_loop_cnt #(
      .INNER_W (TILE_W),
      .OUTER_W (OCG_W)
   ) u_loop_cnt (
      .clk        (sclk),
      .rst_n      (s_rst_n),
      .clr        (cnt_clr),
      .step       (cnt_step),
      .inner_lim  (n_tile_m1),
      .outer_lim  (n_ocg_m1),
      .inner_idx  (tile_idx),
      .outer_idx  (ocg_idx),
      .inner_last (tile_last),
      .outer_last (ocg_last)
   );

   // FSM state register.
   always_ff @(posedge sclk) begin
      if (!s_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and loop-counter control.
   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      cnt_step   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_edge) begin
               state_next = LD_W;
               cnt_clr    = 1'b1;
            end
         end
         LD_W:    state_next = W_WAIT;
         W_WAIT:  if (ldw_done) state_next = LD_F;
         LD_F:    state_next = F_WAIT;
         F_WAIT:  if (ldf_done) state_next = CALC;
         CALC:    state_next = C_WAIT;
         C_WAIT:  if (calc_done) state_next = WB;
         WB:      state_next = WB_WAIT;
         WB_WAIT: begin
            if (wb_done) begin
               cnt_step = 1'b1;
               if (!tile_last) begin
                  state_next = LD_F;
               end else if (!ocg_last) begin
                  state_next = LD_W;
               end else begin
                  state_next = FIN;
               end
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that each pulse appears as a
   // register in the same cycle the FSM sits in the matching state.
   always_ff @(posedge sclk) begin
      if (!s_rst_n) begin
         ldw_start   <= 1'b0;
         ldf_start   <= 1'b0;
         calc_start  <= 1'b0;
         wb_start    <= 1'b0;
         task_finish <= 1'b0;
         busy        <= 1'b0;
      end else begin
         ldw_start   <= (state_next == LD_W);
         ldf_start   <= (state_next == LD_F);
         calc_start  <= (state_next == CALC);
         wb_start    <= (state_next == WB);
         task_finish <= (state_next == FIN);
         busy        <= (state_next != IDLE) && (state_next != FIN);
      end
   end

   // Start-edge history, sticky command error and fields latched at task start.
   always_ff @(posedge sclk) begin
      if (!s_rst_n) begin
         reg0_2_d  <= 1'b0;
         cmd_err   <= 1'b0;
         pool_en   <= 1'b0;
         n_tile_m1 <= '0;
         n_ocg_m1  <= '0;
      end else begin
         reg0_2_d <= slave_lite_reg0[CMD_START_BIT];
         if (start_edge && (state != IDLE)) begin
            cmd_err <= 1'b1;
         end
         if (start_edge && (state == IDLE)) begin
            pool_en   <= slave_lite_reg0[CMD_POOL_BIT];
            n_tile_m1 <= slave_lite_reg0[CMD_NTILE_LSB +: TILE_W];
            n_ocg_m1  <= slave_lite_reg0[CMD_NOCG_LSB +: OCG_W];
         end
      end
   end

endmodule

// File: tb/tb_yolo_task_sched.sv
// Randomised bench for yolo_task_sched with an event-queue reference model.
module tb_yolo_task_sched;

   logic        sclk = 1'b0;
   logic        s_rst_n;
   logic [31:0] slave_lite_reg0;
   logic [3:0]  done_v;
   logic        ldw_start, ldf_start, calc_start, wb_start;
   logic        pool_en, busy, cmd_err, task_finish;
   logic [7:0]  tile_idx, ocg_idx;

   always #5 sclk = ~sclk;

   yolo_task_sched #(.TILE_W(8), .OCG_W(8)) dut (
      .sclk            (sclk),
      .s_rst_n         (s_rst_n),
      .slave_lite_reg0 (slave_lite_reg0),
      .ldw_start       (ldw_start),
      .ldw_done        (done_v[0]),
      .ldf_start       (ldf_start),
      .ldf_done        (done_v[1]),
      .calc_start      (calc_start),
      .calc_done       (done_v[2]),
      .wb_start        (wb_start),
      .wb_done         (done_v[3]),
      .pool_en         (pool_en),
      .tile_idx        (tile_idx),
      .ocg_idx         (ocg_idx),
      .busy            (busy),
      .cmd_err         (cmd_err),
      .task_finish     (task_finish)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Expected pulse sequence of a task: per ocg one weight load, then per tile
   // feature load, compute and write-back; the list ends with the finish pulse.
   typedef struct {int kind; int t; int o;} ev_t;   // kind 0..3 = ldw/ldf/calc/wb, 4 = finish
   ev_t q[$];
   int  mode = 0;          // 0 idle, 1 running (awaiting a done), 2 finish cycle
   int  wait_u = 0;
   bit  armed = 0;
   bit  prev2 = 0;
   logic [3:0] e_start = '0;
   logic e_finish = 0, e_busy = 0, e_cmd_err = 0, e_pool = 0;
   int  e_tile = 0, e_ocg = 0, m_nt = 0, m_no = 0;
   logic [31:0] s_reg0;
   logic s_rst;
   logic [3:0] s_done;
   int  cnt_p[4] = '{default: 0};
   int  lt_p[4]  = '{default: 0};
   int  fin_total = 0;

   task automatic model_step();
      bit   edge_s;
      bit   fire;
      ev_t  ev;
      if (!s_rst) begin
         prev2 = 0; mode = 0; armed = 0; q.delete();
         e_start = '0; e_finish = 0; e_busy = 0; e_cmd_err = 0; e_pool = 0;
         e_tile = 0; e_ocg = 0;
         for (int u = 0; u < 4; u++) cnt_p[u] = 0;
         return;
      end
      edge_s = s_reg0[2] && !prev2;
      prev2  = s_reg0[2];
      e_start = '0;
      e_finish = 0;
      fire = 0;
      case (mode)
         0: if (edge_s) begin
               m_nt = int'(s_reg0[15:8]);
               m_no = int'(s_reg0[23:16]);
               for (int o = 0; o <= m_no; o++) begin
                  q.push_back('{0, 0, o});
                  for (int t = 0; t <= m_nt; t++) begin
                     q.push_back('{1, t, o});
                     q.push_back('{2, t, o});
                     q.push_back('{3, t, o});
                  end
               end
               q.push_back('{4, 0, 0});
               e_pool = s_reg0[3];
               e_busy = 1; e_tile = 0; e_ocg = 0;
               for (int u = 0; u < 4; u++) cnt_p[u] = 0;
               fire = 1;
            end
         1: begin
               if (edge_s) e_cmd_err = 1;
               if (!armed) armed = 1;
               else if (s_done[wait_u]) fire = 1;
            end
         default: begin
               if (edge_s) e_cmd_err = 1;
               mode = 0;
            end
      endcase
      if (fire) begin
         ev = q.pop_front();
         if (ev.kind == 4) begin
            e_finish = 1; e_busy = 0; mode = 2;
         end else begin
            e_start[ev.kind] = 1'b1;
            e_tile = ev.t; e_ocg = ev.o;
            mode = 1; wait_u = ev.kind; armed = 0;
         end
      end
   endtask

   // Single compare process: advance the model on each edge, check outputs mid-cycle.
   always begin
      @(posedge sclk);
      cyc++;
      s_rst  = s_rst_n;
      s_reg0 = slave_lite_reg0;
      s_done = done_v;
      model_step();
      @(negedge sclk);
      chk("ldw_start",   ldw_start,   e_start[0]);
      chk("ldf_start",   ldf_start,   e_start[1]);
      chk("calc_start",  calc_start,  e_start[2]);
      chk("wb_start",    wb_start,    e_start[3]);
      chk("task_finish", task_finish, e_finish);
      chk("busy",        busy,        e_busy);
      chk("cmd_err",     cmd_err,     e_cmd_err);
      chk("pool_en",     pool_en,     e_pool);
      chk("tile_idx",    tile_idx,    e_tile);
      chk("ocg_idx",     ocg_idx,     e_ocg);
      if (ldw_start === 1'b1)  cnt_p[0]++;
      if (ldf_start === 1'b1)  cnt_p[1]++;
      if (calc_start === 1'b1) cnt_p[2]++;
      if (wb_start === 1'b1)   cnt_p[3]++;
      if (task_finish === 1'b1) begin
         fin_total++;
         for (int u = 0; u < 4; u++) lt_p[u] = cnt_p[u];
         chk("ldw_total",  cnt_p[0], m_no + 1);
         chk("ldf_total",  cnt_p[1], (m_nt + 1) * (m_no + 1));
         chk("calc_total", cnt_p[2], (m_nt + 1) * (m_no + 1));
         chk("wb_total",   cnt_p[3], (m_nt + 1) * (m_no + 1));
      end
   end

   // ---------------- sub-unit responders ----------------
   int cnt_d[4] = '{default: 0};
   bit noise_en = 0;
   int dmin = 1, dmax = 4;

   always @(posedge sclk) begin
      logic [3:0] st;
      #1;
      done_v = '0;
      for (int u = 0; u < 4; u++) begin
         if (cnt_d[u] > 0) begin
            cnt_d[u]--;
            if (cnt_d[u] == 0) done_v[u] = 1'b1;
         end
      end
      st = {wb_start, calc_start, ldf_start, ldw_start};
      for (int u = 0; u < 4; u++) begin
         if (st[u]) begin
            cnt_d[u] = int'($urandom_range(dmax, dmin));
            if (noise_en && $urandom_range(0, 3) == 0) done_v[u] = 1'b1;
         end
      end
      if (noise_en && $urandom_range(0, 5) == 0) done_v[$urandom_range(0, 3)] = 1'b1;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic wait_finish(input int limit);
      int n = 0;
      while (task_finish !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      if (task_finish !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL finish_timeout cycle %0d: got no task_finish expected one within %0d cycles", cyc, limit);
      end
   endtask

   task automatic run_task(input logic [31:0] val, input int hold, input int limit);
      slave_lite_reg0 = val;
      repeat (hold) tick();
      slave_lite_reg0 = val & ~32'h4;
      wait_finish(limit);
      tick();
      slave_lite_reg0 = '0;
      tick();
   endtask

   initial begin
      int n;
      int f0;
      int nt, no;
      logic [31:0] val;
      s_rst_n = 1'b0;
      slave_lite_reg0 = '0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_ldw", ldw_start, 0);
      chk("rst_tile", tile_idx, 0);
      chk("rst_cmd_err", cmd_err, 0);
      s_rst_n = 1'b1;
      tick();

      // single tile, single ocg, done 3 cycles after each start
      dmin = 3; dmax = 3;
      run_task(32'h0000_0004, 1, 300);
      chk("t1_ldw", lt_p[0], 1);
      chk("t1_ldf", lt_p[1], 1);
      chk("t1_wb",  lt_p[3], 1);

      // 3 tiles x 2 ocg
      dmin = 1; dmax = 4;
      run_task(32'h0001_0204, 1, 1000);
      chk("t2_ldw", lt_p[0], 2);
      chk("t2_ldf", lt_p[1], 6);
      chk("t2_tile_final", tile_idx, 2);
      chk("t2_ocg_final", ocg_idx, 1);

      // start re-asserted mid-task: sticky cmd_err, loop unaffected
      f0 = fin_total;
      slave_lite_reg0 = 32'h0003_1F8C;
      tick();
      slave_lite_reg0 = 32'h0003_1F88;
      repeat (50) tick();
      slave_lite_reg0 = 32'h0003_1F8C;
      tick();
      slave_lite_reg0 = 32'h0003_1F88;
      wait_finish(20000);
      repeat (20) tick();
      chk("t3_cmd_err", cmd_err, 1);
      chk("t3_pool", pool_en, 1);
      chk("t3_wb", lt_p[3], 128);
      chk("t3_ldw", lt_p[0], 4);
      chk("t3_fin_once", fin_total - f0, 1);
      slave_lite_reg0 = '0;
      s_rst_n = 1'b0;
      tick();
      chk("t3_cmd_err_clr", cmd_err, 0);
      s_rst_n = 1'b1;
      tick();

      // start level held through and past the end of the task
      f0 = fin_total;
      slave_lite_reg0 = 32'h0000_0104;
      wait_finish(2000);
      repeat (30) tick();
      chk("t4_idle", busy, 0);
      chk("t4_no_retrigger", cnt_p[0], 1);
      chk("t4_fin_once", fin_total - f0, 1);
      slave_lite_reg0 = '0;
      tick();

      // spurious and same-cycle done pulses
      noise_en = 1;
      run_task(32'h0002_0304, 2, 4000);
      noise_en = 0;
      chk("t5_wb", lt_p[3], 12);
      chk("t5_ldw", lt_p[0], 3);

      // reset during C_WAIT of tile 1
      dmin = 4; dmax = 4;
      slave_lite_reg0 = 32'h0001_0304;
      tick();
      slave_lite_reg0 = '0;
      n = 0;
      while (!(mode == 1 && wait_u == 2 && e_tile == 1 && armed) && n < 500) begin
         tick();
         n++;
      end
      chk("t6_reached_cwait", n < 500, 1);
      f0 = fin_total;
      s_rst_n = 1'b0;
      tick();
      chk("t6_busy", busy, 0);
      chk("t6_tile", tile_idx, 0);
      s_rst_n = 1'b1;
      repeat (30) tick();
      chk("t6_no_finish", fin_total - f0, 0);
      dmin = 1; dmax = 4;
      run_task(32'h0000_0104, 1, 1000);
      chk("t6_rerun_wb", lt_p[3], 2);

      // counter extremes
      dmin = 1; dmax = 2;
      run_task(32'h0000_FF04, 1, 20000);
      chk("max_tile_wb", lt_p[3], 256);
      chk("max_tile_idx", tile_idx, 255);
      run_task(32'h00FF_0004, 1, 20000);
      chk("max_ocg_ldw", lt_p[0], 256);
      chk("max_ocg_idx", ocg_idx, 255);

      // random commands
      dmin = 1; dmax = 4;
      for (int i = 0; i < 4; i++) begin
         nt = int'($urandom_range(0, 6));
         no = int'($urandom_range(0, 3));
         val = ($urandom & 32'hFF00_00F3) | (32'($urandom_range(0, 1)) << 3) |
               (32'(nt) << 8) | (32'(no) << 16) | 32'h4;
         noise_en = ($urandom_range(0, 1) == 1);
         run_task(val, int'($urandom_range(1, 3)), 4000);
         chk("rand_wb", lt_p[3], (nt + 1) * (no + 1));
      end
      noise_en = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog cycle %0d: got no end of stimulus expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
